dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Load/store front end for the data memory. It sits between the execute/memory pipeline stage and the four byte-wide data memory banks. It converts one 32-bit byte-addressed request per cycle into per-lane bank reads and writes, including per-lane addresses and write-data rotation. It then realigns and sign/zero-extends the returned bank bytes into a 32-bit load result.

## Interface
- ADDR_WIDTH, 8, byte-address width; each bank has ADDR_WIDTH-2 word-address bits
- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- REQ_VALID  in  1  request present
- REQ_READY  out  1  request accepted on edge where REQ_VALID & REQ_READY
- REQ_WE  in  1  1 = store, 0 = load
- REQ_ADDR  in  ADDR_WIDTH  byte address
- REQ_SIZE  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- REQ_UNSIGNED  in  1  load zero-extends when 1, sign-extends when 0
- REQ_WDATA  in  32  store data, LSB-justified
- RSP_VALID  out  1  one-cycle response pulse, for loads and stores
- RSP_ERR  out  1  request was illegal or misaligned-rejected
- RSP_RDATA  out  32  load result; 0 for stores and errors
- BANK_WE  out  4  per-lane write enable; lane i holds bytes with addr[1:0] = i
- BANK_RE  out  4  per-lane read enable
- BANK_W_ADDR  out  4*(ADDR_WIDTH-2)  per-lane word address, lane 0 in LSBs
- BANK_R_ADDR  out  4*(ADDR_WIDTH-2)  per-lane word address, lane 0 in LSBs
- BANK_DIN  out  32  per-lane write byte, lane 0 in [7:0]
- BANK_DOUT  in  32  per-lane registered read byte, valid the cycle after BANK_RE

## Operation
- Byte count n = 1, 2 or 4 from REQ_SIZE; offset o = REQ_ADDR[1:0]; word w = REQ_ADDR[ADDR_WIDTH-1:2].
- Active lanes are (o + k) mod 4 for k = 0..n-1.
- Lane address is w+1 for lanes below o, else w. Word addition wraps modulo 2^(ADDR_WIDTH-2), so the last word + 1 addresses word 0.
- For a store, lane (o+k) mod 4 receives REQ_WDATA byte k.
- For a load, result byte k = BANK_DOUT lane (o+k) mod 4. Bytes n..3 are filled with sign (bit 8n-1) unless REQ_UNSIGNED, then 0.
- Misaligned means half with o = 1 or 3, or word with o != 0. Handling is set by the configuration macro.
- REQ_SIZE = 3 always produces an error.
- An error response asserts no bank enables, gives RSP_ERR = 1 and RSP_RDATA = 0.
- Pipeline stages:
  - S1: request registered at the accept edge; bank outputs are driven from S1 registers.
  - S2: load/store/error tag plus offset, size and unsigned fields follow S1 by one edge.
  - Response register: captures S2's result and BANK_DOUT.
- The pipeline is fully pipelined with one request per cycle. No hazards exist because each request owns the banks for exactly one edge.

## Timing
- Accept at edge E0 → BANK_WE/BANK_RE/addresses/BANK_DIN valid in cycle E0..E1 → bank acts at E1.
- BANK_DOUT is valid in E1..E2. The response is registered at E2, so RSP_VALID is high in cycle E2..E3.
- Latency from accept to RSP_VALID is 2 edges for loads, stores and errors.
- Bank enables are high for exactly one cycle per accepted request. They are 0 in cycles with no S1 request.
- REQ_READY is 0 during reset and rises at the first edge after RST deasserts. It then stays 1, with no backpressure.
- Reset, asynchronous, including mid-operation:
  - REQ_READY, RSP_VALID, RSP_ERR, BANK_WE and BANK_RE go to 0 immediately.
  - RSP_RDATA, BANK_DIN and all addresses go to 0.
  - In-flight requests are dropped with no response.

## Configuration
- DMEM_LSU_MISALIGN_EN defined: misaligned accesses complete in one access using per-lane addresses, including word-wrap crossing, with RSP_ERR = 0.
- DMEM_LSU_MISALIGN_EN undefined: misaligned accesses produce an error response with no bank enables. Aligned behaviour is identical in both builds.

## Test plan
- Store word 0x11223344 at 0x10, then load word 0x10:
  - BANK_WE = 4'b1111 with all addresses 4 for the store.
  - RSP_RDATA = 0x11223344 two edges after the load is accepted.
- Load byte 0x12 containing 0x80:
  - Signed load → 0xFFFFFF80.
  - REQ_UNSIGNED = 1 → 0x00000080.
  - BANK_RE = 4'b0100 in both cases.
- Store half 0xBEEF at 0x07 (misalign enabled):
  - BANK_WE = 4'b1001; lane 3 address 1 with DIN 0xEF; lane 0 address 2 with DIN 0xBE.
  - Loading it back returns 0xFFFFBEEF.
- Word load at 0xFE (ADDR_WIDTH = 8, misalign enabled):
  - Lanes 2,3 use address 63; lanes 0,1 use address 0 (wrap).
- Misalign disabled: half load at 0x01, and separately REQ_SIZE = 3:
  - Each gives RSP_VALID with RSP_ERR = 1, RSP_RDATA = 0 and BANK_RE = 0.
- Back-to-back stream store/load/load on consecutive cycles:
  - Three RSP_VALID pulses on consecutive cycles.
  - Assert RST while the second request is in S1: no further responses, all outputs 0 immediately, REQ_READY returns 1 one edge after release.

Source files
------------

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store front end splitting 32-bit requests onto four byte-wide memory banks.
// Define DMEM_LSU_MISALIGN_EN to service misaligned accesses instead of rejecting them.
module dmem_lsu #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic                        req_we_i,
    input  logic [ADDR_WIDTH-1:0]       req_addr_i,
    input  logic [1:0]                  req_size_i,
    input  logic                        req_unsigned_i,
    input  logic [31:0]                 req_wdata_i,
    output logic                        rsp_valid_o,
    output logic                        rsp_err_o,
    output logic [31:0]                 rsp_rdata_o,
    output logic [3:0]                  bank_we_o,
    output logic [3:0]                  bank_re_o,
    output logic [4*(ADDR_WIDTH-2)-1:0] bank_w_addr_o,
    output logic [4*(ADDR_WIDTH-2)-1:0] bank_r_addr_o,
    output logic [31:0]                 bank_din_o,
    input  logic [31:0]                 bank_dout_i
);
    localparam int WW = ADDR_WIDTH - 2;
    logic            ready_q, accept, err_d;
    logic [1:0]      off;
    logic [WW-1:0]   word, word_inc;
    logic [3:0]      base, lanes_d, we_q, re_q;
    logic [7:0]      rot;
    logic [4*WW-1:0] addr_d, addr_q;
    logic [31:0]     din_d, din_q;
    logic            s1_v_q, s1_we_q, s1_err_q, s1_uns_q;
    logic [1:0]      s1_off_q, s1_size_q;
    logic            s2_v_q, s2_we_q, s2_err_q, s2_uns_q;
    logic [1:0]      s2_off_q, s2_size_q;
    logic            rsp_v_q, rsp_err_q;
    logic [31:0]     aligned, ext, rdata_d, rdata_q;

    always_comb begin
        accept   = req_valid_i & ready_q;
        off      = req_addr_i[1:0];
        word     = req_addr_i[ADDR_WIDTH-1:2];
        word_inc = word + WW'(1);
`ifdef DMEM_LSU_MISALIGN_EN
        err_d    = req_size_i == 2'd3;
`else
        err_d    = (req_size_i == 2'd3) | (req_size_i == 2'd1 & off[0]) | (req_size_i == 2'd2 & off != 2'd0);
`endif
        base     = req_size_i == 2'd0 ? 4'b0001 : req_size_i == 2'd1 ? 4'b0011 : 4'b1111;
        rot      = {4'b0000, base} << off;
        lanes_d  = err_d ? 4'b0000 : rot[3:0] | rot[7:4];
        // store byte k lands on lane (o+k) mod 4: rotate the word left by o bytes
        din_d    = off == 2'd0 ? req_wdata_i :
                   off == 2'd1 ? {req_wdata_i[23:0], req_wdata_i[31:24]} :
                   off == 2'd2 ? {req_wdata_i[15:0], req_wdata_i[31:16]} :
                                 {req_wdata_i[7:0], req_wdata_i[31:8]};
        addr_d   = '0;
        for (int i = 0; i < 4; i++)
            addr_d[i*WW +: WW] = (2'(i) < off) ? word_inc : word;
        aligned  = s2_off_q == 2'd0 ? bank_dout_i :
                   s2_off_q == 2'd1 ? {bank_dout_i[7:0], bank_dout_i[31:8]} :
                   s2_off_q == 2'd2 ? {bank_dout_i[15:0], bank_dout_i[31:16]} :
                                      {bank_dout_i[23:0], bank_dout_i[31:24]};
        ext      = s2_size_q == 2'd0 ? {{24{~s2_uns_q & aligned[7]}}, aligned[7:0]} :
                   s2_size_q == 2'd1 ? {{16{~s2_uns_q & aligned[15]}}, aligned[15:0]} : aligned;
        rdata_d  = (s2_v_q & ~s2_we_q & ~s2_err_q) ? ext : 32'd0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ready_q   <= 1'b0;
            we_q      <= '0;
            re_q      <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            s1_v_q    <= 1'b0;
            s1_we_q   <= 1'b0;
            s1_err_q  <= 1'b0;
            s1_uns_q  <= 1'b0;
            s1_off_q  <= '0;
            s1_size_q <= '0;
            s2_v_q    <= 1'b0;
            s2_we_q   <= 1'b0;
            s2_err_q  <= 1'b0;
            s2_uns_q  <= 1'b0;
            s2_off_q  <= '0;
            s2_size_q <= '0;
            rsp_v_q   <= 1'b0;
            rsp_err_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            ready_q   <= 1'b1;
            we_q      <= {4{accept & req_we_i}} & lanes_d;
            re_q      <= {4{accept & ~req_we_i}} & lanes_d;
            if (accept) begin
                addr_q <= addr_d;
                din_q  <= din_d;
            end
            s1_v_q    <= accept;
            s1_we_q   <= req_we_i;
            s1_err_q  <= err_d;
            s1_uns_q  <= req_unsigned_i;
            s1_off_q  <= off;
            s1_size_q <= req_size_i;
            s2_v_q    <= s1_v_q;
            s2_we_q   <= s1_we_q;
            s2_err_q  <= s1_err_q;
            s2_uns_q  <= s1_uns_q;
            s2_off_q  <= s1_off_q;
            s2_size_q <= s1_size_q;
            rsp_v_q   <= s2_v_q;
            rsp_err_q <= s2_v_q & s2_err_q;
            rdata_q   <= rdata_d;
        end
    end

    assign req_ready_o   = ready_q;
    assign rsp_valid_o   = rsp_v_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_rdata_o   = rdata_q;
    assign bank_we_o     = we_q;
    assign bank_re_o     = re_q;
    assign bank_w_addr_o = addr_q;
    assign bank_r_addr_o = addr_q;
    assign bank_din_o    = din_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: scoreboard bench for dmem_lsu against a byte-addressed reference memory.
module tb_dmem_lsu;
    localparam int AW = 8;
`ifdef DMEM_LSU_MISALIGN_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif
    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_uns = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [1:0]  req_size = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata, bank_din, bdout = '0;
    logic [3:0]  bank_we, bank_re;
    logic [23:0] bank_w_addr, bank_r_addr;
    int          errors = 0, checks = 0, cyc = 0;
    logic [7:0]  ref_mem [256];
    logic [7:0]  bmem [4][64];

    typedef struct {int due; bit err; logic [31:0] rd;} rsp_t;
    typedef struct {logic [3:0] we, re; logic [23:0] la; logic [31:0] ld;} bank_t;
    rsp_t  rq[$];
    bank_t bq[$];
    rsp_t  me;
    bank_t mb;

    dmem_lsu #(.ADDR_WIDTH(AW)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_size_i(req_size),
        .req_unsigned_i(req_uns), .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid),
        .rsp_err_o(rsp_err), .rsp_rdata_o(rsp_rdata), .bank_we_o(bank_we), .bank_re_o(bank_re),
        .bank_w_addr_o(bank_w_addr), .bank_r_addr_o(bank_r_addr), .bank_din_o(bank_din),
        .bank_dout_i(bdout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] seed_byte(int a);
        return 8'((a * 97 + 13) ^ (a >> 3));
    endfunction

    function void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // byte-wide banks with registered read data
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int a = 0; a < 256; a++) bmem[a % 4][a / 4] <= seed_byte(a);
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (bank_we[i]) bmem[i][bank_w_addr[i*6 +: 6]] <= bank_din[i*8 +: 8];
                if (bank_re[i]) bdout[i*8 +: 8] <= bmem[i][bank_r_addr[i*6 +: 6]];
            end
        end
    end

    always @(negedge clk) begin
        while (rq.size() != 0 && rq[0].due < cyc) begin
            chk("rsp_missing_due", cyc, rq[0].due);
            void'(rq.pop_front());
        end
        if (rsp_valid) begin
            if (rq.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            else begin
                me = rq.pop_front();
                chk("rsp_cycle", cyc, me.due);
                chk("rsp_err", 32'(rsp_err), 32'(me.err));
                chk("rsp_rdata", rsp_rdata, me.rd);
            end
        end
        if (bq.size() != 0) begin
            mb = bq.pop_front();
            chk("bank_we", 32'(bank_we), 32'(mb.we));
            chk("bank_re", 32'(bank_re), 32'(mb.re));
            for (int i = 0; i < 4; i++) begin
                if (mb.we[i]) begin
                    chk("bank_w_addr", 32'(bank_w_addr[i*6 +: 6]), 32'(mb.la[i*6 +: 6]));
                    chk("bank_din", 32'(bank_din[i*8 +: 8]), 32'(mb.ld[i*8 +: 8]));
                end
                if (mb.re[i]) chk("bank_r_addr", 32'(bank_r_addr[i*6 +: 6]), 32'(mb.la[i*6 +: 6]));
            end
        end else chk("bank_idle", {24'd0, bank_we, bank_re}, 32'd0);
    end

    task automatic issue(input bit we, input logic [7:0] a, input logic [1:0] sz, input bit uns, input logic [31:0] wd);
        rsp_t r;
        bank_t b;
        int n, lane;
        logic [7:0] ba;
        logic [31:0] v;
        req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz; req_uns = uns; req_wdata = wd;
        chk("req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
        r.due = cyc + 2;
        r.err = sz == 2'd3 || (!MIS && (int'(a) % n) != 0);
        b.we = '0; b.re = '0; b.la = '0; b.ld = '0; v = '0;
        if (!r.err) begin
            for (int k = 0; k < n; k++) begin
                ba = a + 8'(k);
                lane = int'(ba) % 4;
                b.we[lane] = we;
                b.re[lane] = !we;
                b.la[lane*6 +: 6] = 6'(int'(ba) / 4);
                b.ld[lane*8 +: 8] = wd[k*8 +: 8];
                if (we) ref_mem[ba] = wd[k*8 +: 8];
                else v[k*8 +: 8] = ref_mem[ba];
            end
            if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        end
        r.rd = (r.err || we) ? 32'd0 : v;
        rq.push_back(r);
        bq.push_back(b);
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_we_re"}, {24'd0, bank_we, bank_re}, 32'd0);
        chk({tag, "_addrs"}, {8'd0, bank_w_addr | bank_r_addr}, 32'd0);
        chk({tag, "_din"}, bank_din, 32'd0);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) ref_mem[a] = seed_byte(a);
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        rst = 1'b0;
        #1 chk("ready_before_edge", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("ready_after_release", 32'(req_ready), 32'd1);
        issue(1, 8'h10, 2'd2, 0, 32'h1122_3344);
        issue(0, 8'h10, 2'd2, 0, 32'h0);
        issue(1, 8'h12, 2'd0, 0, 32'h0000_0080);
        issue(0, 8'h12, 2'd0, 0, 32'h0);
        issue(0, 8'h12, 2'd0, 1, 32'h0);
        issue(1, 8'h07, 2'd1, 0, 32'h0000_BEEF);
        issue(0, 8'h07, 2'd1, 0, 32'h0);
        issue(0, 8'hFE, 2'd2, 0, 32'h0);
        issue(0, 8'h01, 2'd1, 0, 32'h0);
        issue(0, 8'h00, 2'd3, 0, 32'h0);
        issue(1, 8'h20, 2'd2, 0, 32'hA5A5_5A5A);
        issue(0, 8'h20, 2'd2, 0, 32'h0);
        issue(0, 8'h21, 2'd0, 0, 32'h0);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk); #1;
            end else
                issue(1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), $urandom);
        end
        repeat (4) @(posedge clk);
        #1;
        // reset lands while the load is in S1; the store already reached the banks
        issue(1, 8'h40, 2'd2, 0, 32'hCAFE_F00D);
        issue(0, 8'h40, 2'd2, 0, 32'h0);
        rst = 1'b1;
        rq.delete();
        bq.delete();
        #1 check_zero("midreset");
        repeat (2) @(posedge clk);
        #1 chk("ready_in_reset", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1 chk("ready_pre_edge", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("ready_post_reset", 32'(req_ready), 32'd1);
        issue(0, 8'h40, 2'd2, 0, 32'h0);
        repeat (4) @(posedge clk);
        #1 chk("queue_drained", 32'(rq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
